// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor: one bit per cycle, LSB first, with a
// one-cycle done pulse and result registers that hold between operations.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] difference,
  output logic         borrow_out
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_next;

  logic [N-1:0]  a_sr, b_sr, res_sr;
  logic [CW-1:0] count;
  logic          borrow;
  logic          d_bit, bout_bit;
  logic          last_bit;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // The final bit is folded into the result as it is loaded, so difference
  // already holds the complete word during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      count      <= '0;
      borrow     <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= minuend;
            b_sr   <= subtrahend;
            borrow <= 1'b0;
            count  <= '0;
          end
        end
        RUN: begin
          res_sr <= {d_bit, res_sr[N-1:1]};
          borrow <= bout_bit;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (last_bit) begin
            difference <= {d_bit, res_sr[N-1:1]};
            borrow_out <= bout_bit;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=4) with hand-computed expectations
// checked cycle by cycle against the documented latency.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] minuend;
  logic [N-1:0] subtrahend;
  logic         busy;
  logic         done;
  logic [N-1:0] difference;
  logic         borrow_out;

  int total_checks;
  int passed_checks;

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Called at a negedge; the next posedge accepts the start. When hold_start
  // is set, start stays high and the operands are swapped mid-run.
  task automatic apply_stimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [N-1:0] exp_d, input logic exp_b,
                                input logic [N-1:0] prev_d, input logic prev_b,
                                input logic hold_start,
                                input logic [N-1:0] alt_a, input logic [N-1:0] alt_b);
    minuend    = a;
    subtrahend = b;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("busy_after_start", 32'(busy), 32'd1);
    if (hold_start) begin
      minuend    = alt_a;
      subtrahend = alt_b;
    end else begin
      start = 1'b0;
    end
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      check_output("done_low_in_run", 32'(done), 32'd0);
      check_output("busy_in_run", 32'(busy), 32'd1);
      check_output("diff_holds", 32'(difference), 32'(prev_d));
      check_output("borrow_holds", 32'(borrow_out), 32'(prev_b));
    end
    @(negedge clk);
    check_output("done_pulse", 32'(done), 32'd1);
    check_output("busy_in_done", 32'(busy), 32'd1);
    check_output("difference", 32'(difference), 32'(exp_d));
    check_output("borrow_out", 32'(borrow_out), 32'(exp_b));
    @(negedge clk);
    check_output("done_one_cycle", 32'(done), 32'd0);
    check_output("idle_gap", 32'(busy), 32'd0);
    check_output("diff_after_done", 32'(difference), 32'(exp_d));
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst        = 1'b1;
    start      = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_diff", 32'(difference), 32'd0);
    check_output("reset_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    apply_stimulus(4'd9,  4'd3,  4'd6,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0);
    apply_stimulus(4'd3,  4'd9,  4'hA,  1'b1, 4'd6,  1'b0, 1'b0, 4'd0, 4'd0);
    apply_stimulus(4'd15, 4'd15, 4'd0,  1'b0, 4'hA,  1'b1, 1'b0, 4'd0, 4'd0);
    apply_stimulus(4'd0,  4'd1,  4'hF,  1'b1, 4'd0,  1'b0, 1'b0, 4'd0, 4'd0);

    // Start held through the whole run with operands changed mid-run, then
    // a back-to-back operation with the new operands: 1 - 14 = 3, borrow.
    apply_stimulus(4'd12, 4'd5,  4'd7,  1'b0, 4'hF,  1'b1, 1'b1, 4'd1, 4'd14);
    apply_stimulus(4'd1,  4'd14, 4'd3,  1'b1, 4'd7,  1'b0, 1'b0, 4'd0, 4'd0);

    // Reset arriving at the second RUN cycle aborts without a done pulse.
    minuend    = 4'd9;
    subtrahend = 4'd3;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_diff", 32'(difference), 32'd0);
    check_output("abort_borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_output("abort_no_done", 32'(done), 32'd0);
    end

    // Reset wins over start; the first edge after release accepts it.
    rst        = 1'b1;
    minuend    = 4'd5;
    subtrahend = 4'd2;
    start      = 1'b1;
    @(negedge clk);
    check_output("reset_over_start", 32'(busy), 32'd0);
    rst = 1'b0;
    apply_stimulus(4'd5, 4'd2, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL expose parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port list (name  direction  width  meaning), in this order:
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a new subtraction; sampled only in IDLE.
REQ-007 minuend  input  N  unsigned operand A; captured on an accepted start.
REQ-008 subtrahend  input  N  unsigned operand B; captured on an accepted start.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 difference  output  N  result equal to (A - B) mod 2^N.
REQ-012 borrow_out  output  1  high iff A < B (unsigned).

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, with encoding constants taken from the shared package.
REQ-014 IDLE with start=1 -> RUN; in the same edge, capture A and B into shift registers, clear the borrow register, and clear the bit counter.
REQ-015 IDLE with start=0 -> stay in IDLE.
REQ-016 Start SHALL be ignored in RUN and DONE, with no effect on operands or outputs.
REQ-017 RUN SHALL process one bit per cycle, LSB first, via the full_subtractor sub-module:
  - inputs: a_sr[0], b_sr[0], borrow register;
  - the diff bit shifts into the MSB of the result shift register;
  - the borrow register updates;
  - a_sr and b_sr shift right;
  - the counter increments.
REQ-018 When the counter reaches N-1 in RUN, the next edge SHALL go to DONE and load difference and borrow_out from the completed result and final borrow.
REQ-019 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency: start accepted at edge T -> done=1 during the cycle after edge T+N; the next start is accepted no earlier than edge T+N+2.
REQ-021 difference and borrow_out SHALL change only on the edge entering DONE, and SHALL hold between results, including during a later RUN.
REQ-022 Counter width SHALL be clog2(N); it does not wrap, because the FSM leaves RUN on count N-1.
REQ-023 Subtraction identities (A=B gives 0 with borrow 0; B=0 gives A with borrow 0) SHALL need no special-case logic.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, and SHALL clear busy, done, difference, borrow_out, the counter, the borrow register and all shift registers.
REQ-025 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.
REQ-026 After rst deasserts, start SHALL be accepted on the first edge.

Structure
REQ-027 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared package/header.
REQ-028 The 1-bit full_subtractor (inputs a, b, bin; outputs d, bout) SHALL be the single sub-module, purely combinational.
REQ-029 All sequential logic SHALL reside in serial_subtractor.

Verification (N=4)
REQ-030 Normal subtraction: A=9, B=3, start pulse at edge T -> done at T+5 with difference=6, borrow_out=0; busy high for cycles T+1..T+5.
REQ-031 Underflow: A=3, B=9 -> difference=4'hA, borrow_out=1.
REQ-032 Edge operands:
  - A=15, B=15 -> difference 0, borrow_out 0;
  - A=0, B=1 -> difference 4'hF, borrow_out 1.
REQ-033 Start while busy: start held high for the whole RUN with operands changed mid-run -> result is from the first operands only, exactly one done pulse, then a new operation starts from IDLE.
REQ-034 Reset mid-operation: rst at the second RUN cycle -> no done pulse, and all outputs read 0 on the next cycle.
REQ-035 Back-to-back: start held continuously -> operations separated by exactly one IDLE cycle, and results hold between done pulses.
